motor_pwm_ramp: RTL and testbench

MOTOR_PWM_RAMP -- requirements
Module: motor_pwm_ramp

---
 rtl/motor_pwm_ramp.sv | 226 ++++++++++++++++++++++
 tb/tb_motor_pwm_ramp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_ramp
// Description : Multi-channel H-bridge motor driver with a shared PWM period,
//               per-channel speed ramping, reversal dead time and braking.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_ramp #(
    parameter int NCH     = 2,
    parameter int PERIOD  = 100000,
    parameter int SPD_W   = 4,
    parameter int SPD_MAX = 10,
    parameter int RAMP_P  = 4,
    parameter int DEAD_P  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         forward,
    input  logic [NCH-1:0]         brake,
    input  logic [NCH*SPD_W-1:0]   speed,
    output logic [NCH-1:0]         pwm,
    output logic [NCH-1:0]         in1,
    output logic [NCH-1:0]         in2,
    output logic [NCH-1:0]         status_led,
    output logic [NCH*SPD_W-1:0]   cur_speed,
    output logic                   period_tick
);

    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int PROD_W = CNT_W + SPD_W;
    localparam int RDIV_W = (RAMP_P > 1) ? $clog2(RAMP_P) : 1;
    localparam int DEAD_W = (DEAD_P > 1) ? $clog2(DEAD_P) : 1;

    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [SPD_W-1:0]  C_SPD_MAX   = SPD_W'(SPD_MAX);
    localparam logic [RDIV_W-1:0] C_RDIV_LAST = RDIV_W'(RAMP_P - 1);
    localparam logic [DEAD_W-1:0] C_DEAD_LAST = DEAD_W'(DEAD_P - 1);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STOP  = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
    localparam logic [2:0] ST_BRAKE = 3'd4;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap        = (cnt_q == C_CNT_LAST);
    assign period_tick = wrap;

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SPD_W-1:0]  tgt;
        logic [2:0]        state_q, state_d;
        logic              dir_q, dir_d;
        logic [SPD_W-1:0]  spd_q, spd_d;
        logic [RDIV_W-1:0] div_q, div_d;
        logic [DEAD_W-1:0] dead_q, dead_d;
        logic [CNT_W-1:0]  th_q, th_d;
        logic              pwm_q, pwm_d;
        logic              in1_q, in1_d;
        logic              in2_q, in2_d;
        logic              led_q, led_d;
        logic              ramp_hit;
        logic              dead_done;
        logic              drive;

        assign tgt = (speed[i*SPD_W +: SPD_W] > C_SPD_MAX) ? C_SPD_MAX
                                                           : speed[i*SPD_W +: SPD_W];
        assign ramp_hit  = (div_q == C_RDIV_LAST);
        assign dead_done = (DEAD_P <= 1) || (dead_q == C_DEAD_LAST);

        // en and brake override immediately; everything else advances per period
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            spd_d   = spd_q;
            div_d   = div_q;
            dead_d  = dead_q;
            if (!en[i]) begin
                state_d = ST_OFF;
                spd_d   = '0;
                div_d   = '0;
                dead_d  = '0;
            end else if (brake[i]) begin
                state_d = ST_BRAKE;
                spd_d   = '0;
                div_d   = '0;
                dead_d  = '0;
            end else if (wrap) begin
                case (state_q)
                    ST_OFF: begin
                        state_d = ST_RUN;
                        dir_d   = forward[i];
                        spd_d   = '0;
                        div_d   = '0;
                    end
                    ST_RUN: begin
                        if (forward[i] != dir_q) begin
                            state_d = ST_STOP;
                            div_d   = '0;
                        end else if (ramp_hit) begin
                            div_d = '0;
                            if (spd_q < tgt) begin
                                spd_d = spd_q + 1'b1;
                            end else if (spd_q > tgt) begin
                                spd_d = spd_q - 1'b1;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (forward[i] == dir_q) begin
                            state_d = ST_RUN;
                            div_d   = '0;
                        end else if (spd_q == '0) begin
                            state_d = ST_DEAD;
                            dead_d  = '0;
                        end else if (ramp_hit) begin
                            div_d = '0;
                            spd_d = spd_q - 1'b1;
                            if (spd_q == SPD_W'(1)) begin
                                state_d = ST_DEAD;
                                dead_d  = '0;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_done) begin
                            state_d = ST_RUN;
                            dir_d   = forward[i];
                            spd_d   = '0;
                            div_d   = '0;
                            dead_d  = '0;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                    ST_BRAKE: begin
                        state_d = ST_DEAD;
                        spd_d   = '0;
                        dead_d  = '0;
                    end
                    default: begin
                        state_d = ST_OFF;
                        spd_d   = '0;
                    end
                endcase
            end
        end

        // Threshold is taken from the speed that will be shown for the new period
        always_comb begin
            th_d = th_q;
            if (wrap) begin
                th_d = CNT_W'((PROD_W'(PERIOD) * PROD_W'(spd_d)) / PROD_W'(SPD_MAX));
            end
        end

        assign drive = (state_d == ST_RUN) || (state_d == ST_STOP);

        always_comb begin
            pwm_d = drive && (cnt_d < th_d);
            led_d = (state_d != ST_OFF);
            in1_d = 1'b0;
            in2_d = 1'b0;
            if (drive) begin
                in1_d = dir_d;
                in2_d = ~dir_d;
            end else if (state_d == ST_BRAKE) begin
                in1_d = 1'b1;
                in2_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_OFF;
                dir_q   <= 1'b0;
                spd_q   <= '0;
                div_q   <= '0;
                dead_q  <= '0;
                th_q    <= '0;
                pwm_q   <= 1'b0;
                in1_q   <= 1'b0;
                in2_q   <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                spd_q   <= spd_d;
                div_q   <= div_d;
                dead_q  <= dead_d;
                th_q    <= th_d;
                pwm_q   <= pwm_d;
                in1_q   <= in1_d;
                in2_q   <= in2_d;
                led_q   <= led_d;
            end
        end

        assign pwm[i]                       = pwm_q;
        assign in1[i]                       = in1_q;
        assign in2[i]                       = in2_q;
        assign status_led[i]                = led_q;
        assign cur_speed[i*SPD_W +: SPD_W]  = spd_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_pwm_ramp
// Description : Scoreboard bench for motor_pwm_ramp with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_ramp;

    localparam int NCH     = 2;
    localparam int PERIOD  = 100;
    localparam int SPD_W   = 4;
    localparam int SPD_MAX = 10;
    localparam int RAMP_P  = 1;
    localparam int DEAD_P  = 2;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b1;
    logic [NCH-1:0]       en      = '0;
    logic [NCH-1:0]       forward = '1;
    logic [NCH-1:0]       brake   = '0;
    logic [NCH*SPD_W-1:0] speed   = {4'd7, 4'd5};
    logic [NCH-1:0]       pwm;
    logic [NCH-1:0]       in1;
    logic [NCH-1:0]       in2;
    logic [NCH-1:0]       status_led;
    logic [NCH*SPD_W-1:0] cur_speed;
    logic                 period_tick;

    always #5 clk = ~clk;

    motor_pwm_ramp #(
        .NCH     (NCH),
        .PERIOD  (PERIOD),
        .SPD_W   (SPD_W),
        .SPD_MAX (SPD_MAX),
        .RAMP_P  (RAMP_P),
        .DEAD_P  (DEAD_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .forward     (forward),
        .brake       (brake),
        .speed       (speed),
        .pwm         (pwm),
        .in1         (in1),
        .in2         (in2),
        .status_led  (status_led),
        .cur_speed   (cur_speed),
        .period_tick (period_tick)
    );

    typedef struct {
        int    cyc;
        bit    per;
        int    ch;
        int    pv;
        bit    in1;
        bit    in2;
        bit    led;
        int    spd;
        bit    tick;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   mcnt   = 0;
    int   errors = 0;
    int   checks = 0;
    int   acc[NCH];

    // Expected speeds per period, worked out by hand from the ramp rules
    int st0[9]  = '{0, 1, 2, 3, 4, 5, 5, 5, 5};
    int st1[9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 7};
    int rv_s[10] = '{5, 4, 3, 2, 1, 0, 0, 0, 1, 2};
    int rv_1[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int rv_2[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int sat[9]  = '{3, 4, 5, 6, 7, 8, 9, 10, 10};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || mcnt == PERIOD - 1) mcnt <= 0;
        else                           mcnt <= mcnt + 1;
    end

    task automatic check_one(input exp_t e);
        int pv;
        int as;
        bit a1, a2, al, ok;
        pv = e.per ? acc[e.ch] : int'(pwm[e.ch]);
        a1 = in1[e.ch];
        a2 = in2[e.ch];
        al = status_led[e.ch];
        as = int'(cur_speed[e.ch*SPD_W +: SPD_W]);
        ok = (pv == e.pv) && (a1 == e.in1) && (a2 == e.in2) && (as == e.spd)
             && (period_tick == e.tick) && (e.per || (al == e.led));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ch%0d cyc%0d: got %s=%0d in1=%0b in2=%0b led=%0b spd=%0d tick=%0b, want %0d in1=%0b in2=%0b led=%0b spd=%0d tick=%0b",
                     e.name, e.ch, cyc, e.per ? "high" : "pwm", pv, a1, a2, al, as,
                     period_tick, e.pv, e.in1, e.in2, e.led, e.spd, e.tick);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            acc[c] = (mcnt == 0) ? int'(pwm[c]) : acc[c] + int'(pwm[c]);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                check_one(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic exp_now(input int ch, input bit p, input bit i1, input bit i2,
                           input bit l, input int s, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.per = 1'b0; e.ch = ch; e.pv = int'(p);
        e.in1 = i1; e.in2 = i2; e.led = l; e.spd = s; e.tick = 1'b0; e.name = nm;
        sb.push_back(e);
    endtask

    // Called on the last cycle of a period; checks the whole following period
    task automatic exp_per(input int ch, input int hi, input bit i1, input bit i2,
                           input int s, input string nm);
        exp_t e;
        e.cyc = cyc + PERIOD; e.per = 1'b1; e.ch = ch; e.pv = hi;
        e.in1 = i1; e.in2 = i2; e.led = 1'b0; e.spd = s; e.tick = 1'b1; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mcnt != v && n < 4 * PERIOD);
    endtask

    task automatic wait_end();
        wait_cnt(PERIOD - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        exp_now(0, 0, 0, 0, 0, 0, "reset");
        exp_now(1, 0, 0, 0, 0, 0, "reset");
        @(negedge clk);
        rst = 1'b0;
        en  = '1;
        wait_end();

        for (int n = 0; n < 9; n++) begin
            exp_per(0, st0[n] * 10, 1, 0, st0[n], "startup");
            exp_per(1, st1[n] * 10, 1, 0, st1[n], "startup");
            wait_end();
        end

        forward[0] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            exp_per(0, rv_s[n] * 10, rv_1[n] != 0, rv_2[n] != 0, rv_s[n], "reverse");
            exp_per(1, 70, 1, 0, 7, "indep");
            wait_end();
        end

        speed[3:0] = 4'd15;
        for (int n = 0; n < 9; n++) begin
            exp_per(0, sat[n] * 10, 0, 1, sat[n], "saturate");
            exp_per(1, 70, 1, 0, 7, "indep");
            wait_end();
        end

        // Brake at count 40 of a full-duty period: 41 high samples then none
        exp_per(0, 41, 1, 1, 0, "brake_per");
        exp_per(1, 70, 1, 0, 7, "indep");
        wait_cnt(40);
        brake[0] = 1'b1;
        exp_now(0, 0, 1, 1, 1, 0, "brake_now");
        exp_now(1, 1, 1, 0, 1, 7, "indep_now");
        wait_end();
        brake[0] = 1'b0;
        exp_per(0, 0, 0, 0, 0, "brake_dead");
        wait_end();
        exp_per(0, 0, 0, 0, 0, "brake_dead");
        wait_end();
        exp_per(0, 0, 0, 1, 0, "brake_run");
        wait_end();
        exp_per(0, 10, 0, 1, 1, "brake_run");
        wait_end();

        // Disable at count 10 while running at speed 2 (threshold 20)
        exp_per(0, 11, 0, 0, 0, "disable_per");
        wait_cnt(10);
        en[0] = 1'b0;
        exp_now(0, 0, 0, 0, 0, 0, "disable_now");
        exp_now(1, 1, 1, 0, 1, 7, "indep_now");
        wait_end();

        wait_cnt(10);
        rst = 1'b1;
        exp_now(0, 0, 0, 0, 0, 0, "rst_now");
        exp_now(1, 0, 0, 0, 0, 0, "rst_now");
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        en      = '1;
        forward = '1;
        wait_end();
        exp_per(0, 0, 1, 0, 0, "resume");
        exp_per(1, 0, 1, 0, 0, "resume");
        wait_end();
        exp_per(0, 10, 1, 0, 1, "resume");
        exp_per(1, 10, 1, 0, 1, "resume");
        wait_end();
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
